// File: rtl/stopwatch_counter.sv
// stopwatch_counter: run/pause/lap timing core, 10 ms ticks, BCD 00.00-59.99.
// Digit increments are produced by the conditional-sum adder csa below.

module csa #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s
);
  logic [N-1:0] s0, s1, c0, c1;

  assign s0 = a ^ b;
  assign s1 = ~(a ^ b);
  assign c0 = a & b;
  assign c1 = a | b;

  // each bit has both sums ready; the incoming carry only selects
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = c ? s1[i] : s0[i];
      c    = c ? c1[i] : c0[i];
    end
  end
endmodule

module stopwatch_counter #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [2:0] disp_s_tens,
  output logic [3:0] disp_s_ones,
  output logic [3:0] disp_cs_tens,
  output logic [3:0] disp_cs_ones,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0] presc, presc_nx;
  logic [3:0] cs1, cs10, s1, s10;
  logic [3:0] cs1_nx, cs10_nx, s1_nx, s10_nx;
  logic [3:0] cs1_inc, cs10_inc, s1_inc, s10_inc;
  logic [3:0] lap_cs1, lap_cs10, lap_s1;
  logic [2:0] lap_s10;
  logic active, tick, zap, cy1, cy2, cy3, roll, lap_enter;

  csa #(.N(4)) u_csa_cs1 (
    .a(cs1), .b(4'd0), .ci(1'b1), .s(cs1_inc)
  );
  csa #(.N(4)) u_csa_cs10 (
    .a(cs10), .b(4'd0), .ci(1'b1), .s(cs10_inc)
  );
  csa #(.N(4)) u_csa_s1 (
    .a(s1), .b(4'd0), .ci(1'b1), .s(s1_inc)
  );
  csa #(.N(4)) u_csa_s10 (
    .a(s10), .b(4'd0), .ci(1'b1), .s(s10_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_stop) state_nx = RUN;
      RUN: begin
        if (start_stop) state_nx = PAUSE;
        else if (lap)   state_nx = LAP;
      end
      LAP: begin
        if (start_stop) state_nx = PAUSE;
        else if (lap)   state_nx = RUN;
      end
      PAUSE: begin
        if (clear)           state_nx = IDLE;
        else if (start_stop) state_nx = RUN;
      end
    endcase
  end

  assign active    = (state == RUN) || (state == LAP);
  assign tick      = active && (presc == PMAX);
  assign zap       = (state == PAUSE) && clear;
  assign cy1       = tick && (cs1 == 4'd9);
  assign cy2       = cy1 && (cs10 == 4'd9);
  assign cy3       = cy2 && (s1 == 4'd9);
  assign roll      = cy3 && (s10 == 4'd5);
  assign lap_enter = (state_nx == LAP) && (state != LAP);

  always_comb begin
    presc_nx = presc;
    if (zap)         presc_nx = '0;
    else if (active) presc_nx = tick ? '0 : presc + PW'(1);
  end

  always_comb begin
    cs1_nx  = cs1;
    cs10_nx = cs10;
    s1_nx   = s1;
    s10_nx  = s10;
    if (zap) begin
      cs1_nx  = '0;
      cs10_nx = '0;
      s1_nx   = '0;
      s10_nx  = '0;
    end else begin
      if (tick) cs1_nx  = (cs1 < 4'd9)  ? cs1_inc  : 4'd0;
      if (cy1)  cs10_nx = (cs10 < 4'd9) ? cs10_inc : 4'd0;
      if (cy2)  s1_nx   = (s1 < 4'd9)   ? s1_inc   : 4'd0;
      if (cy3)  s10_nx  = (s10 < 4'd5)  ? s10_inc  : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      cs1          <= '0;
      cs10         <= '0;
      s1           <= '0;
      s10          <= '0;
      lap_cs1      <= '0;
      lap_cs10     <= '0;
      lap_s1       <= '0;
      lap_s10      <= '0;
      disp_cs_ones <= '0;
      disp_cs_tens <= '0;
      disp_s_ones  <= '0;
      disp_s_tens  <= '0;
      running      <= 1'b0;
      lap_active   <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      presc      <= presc_nx;
      cs1        <= cs1_nx;
      cs10       <= cs10_nx;
      s1         <= s1_nx;
      s10        <= s10_nx;
      wrap       <= roll;
      running    <= (state_nx == RUN) || (state_nx == LAP);
      lap_active <= (state_nx == LAP);
      // lap freezes the count seen before this edge, not the ticked one
      if (lap_enter) begin
        lap_cs1  <= cs1;
        lap_cs10 <= cs10;
        lap_s1   <= s1;
        lap_s10  <= s10[2:0];
      end
      if (lap_enter) begin
        disp_cs_ones <= cs1;
        disp_cs_tens <= cs10;
        disp_s_ones  <= s1;
        disp_s_tens  <= s10[2:0];
      end else if (state_nx == LAP) begin
        disp_cs_ones <= lap_cs1;
        disp_cs_tens <= lap_cs10;
        disp_s_ones  <= lap_s1;
        disp_s_tens  <= lap_s10;
      end else begin
        disp_cs_ones <= cs1_nx;
        disp_cs_tens <= cs10_nx;
        disp_s_ones  <= s1_nx;
        disp_s_tens  <= s10_nx[2:0];
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: vector table, directed corner sequences and
// random pulses against an integer-hundredths reference model.

module tb_stopwatch_counter;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n, start_stop, lap, clear;
  logic [2:0] disp_s_tens;
  logic [3:0] disp_s_ones, disp_cs_tens, disp_cs_ones;
  logic running, lap_active, wrap;

  int passed = 0;
  int total = 0;

  // reference: mode 0 idle, 1 run, 2 pause, 3 lap
  int m_mode, m_cnt, m_phase, m_lapv;
  bit m_wrap, m_tick;

  typedef struct {
    bit ss;
    bit lp;
    bit cl;
    int disp;
    bit run;
    bit lpa;
    bit wr;
  } vec_t;

  vec_t vt[13];

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_stop(start_stop),
    .lap(lap),
    .clear(clear),
    .disp_s_tens(disp_s_tens),
    .disp_s_ones(disp_s_ones),
    .disp_cs_tens(disp_cs_tens),
    .disp_cs_ones(disp_cs_ones),
    .running(running),
    .lap_active(lap_active),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] to_bcd(int v);
    logic [14:0] r;
    r[14:12] = 3'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [17:0] exp_word(int d, bit r, bit l, bit w);
    return {to_bcd(d), r, l, w};
  endfunction

  function automatic logic [17:0] act_word();
    return {disp_s_tens, disp_s_ones, disp_cs_tens, disp_cs_ones,
            running, lap_active, wrap};
  endfunction

  task automatic check(string name, logic [17:0] act, logic [17:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_phase = 0; m_lapv = 0;
    m_wrap = 0; m_tick = 0;
  endtask

  task automatic model_step(bit ss, bit lp, bit cl);
    int old;
    old = m_cnt;
    m_tick = 0;
    m_wrap = 0;
    if (m_mode == 1 || m_mode == 3) begin
      if (m_phase == TD - 1) begin
        m_phase = 0;
        m_tick = 1;
      end else m_phase++;
    end
    if (m_tick) begin
      m_cnt = (m_cnt + 1) % 6000;
      m_wrap = (old == 5999);
    end
    case (m_mode)
      0: if (ss) m_mode = 1;
      1: if (ss) m_mode = 2;
         else if (lp) begin m_mode = 3; m_lapv = old; end
      3: if (ss) m_mode = 2;
         else if (lp) m_mode = 1;
      2: if (cl) begin m_mode = 0; m_cnt = 0; m_phase = 0; end
         else if (ss) m_mode = 1;
      default: m_mode = 0;
    endcase
  endtask

  function automatic logic [17:0] model_word();
    return exp_word(m_mode == 3 ? m_lapv : m_cnt,
                    m_mode == 1 || m_mode == 3, m_mode == 3, m_wrap);
  endfunction

  task automatic cycle(bit ss, bit lp, bit cl, bit chk);
    start_stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    model_step(ss, lp, cl);
    #1;
    start_stop = 0; lap = 0; clear = 0;
    if (chk) check("model", act_word(), model_word());
  endtask

  task automatic run_to(int target, bit chk);
    int n;
    n = 0;
    while (m_cnt != target && n < 30000) begin
      cycle(0, 0, 0, chk);
      n++;
    end
  endtask

  initial begin
    int v, n;
    vt = '{
      '{1, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0},
      '{0, 0, 1, 1, 1, 0, 0},
      '{0, 1, 0, 1, 1, 1, 0},
      '{0, 0, 0, 1, 1, 1, 0},
      '{0, 0, 0, 1, 1, 1, 0},
      '{1, 1, 0, 2, 0, 0, 0},
      '{0, 1, 0, 2, 0, 0, 0},
      '{0, 0, 1, 0, 0, 0, 0},
      '{1, 0, 0, 0, 1, 0, 0}
    };
    start_stop = 0; lap = 0; clear = 0;
    rst_n = 0;
    model_reset();
    #2;
    check("reset", act_word(), exp_word(0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].ss, vt[i].lp, vt[i].cl, 0);
      check($sformatf("vec%0d", i), act_word(),
            exp_word(vt[i].disp, vt[i].run, vt[i].lpa, vt[i].wr));
    end

    repeat (40) cycle(0, 0, 0, 0);
    check("forty_edges", act_word(), exp_word(10, 1, 0, 0));

    // clear ignored in run, then clear beats start_stop in pause
    run_to(37, 0);
    cycle(0, 0, 1, 0);
    check("clr_in_run", act_word(), exp_word(37, 1, 0, 0));
    cycle(1, 0, 0, 0);
    check("pause37", act_word(), exp_word(37, 0, 0, 0));
    cycle(1, 0, 1, 0);
    check("clr_pause", act_word(), exp_word(0, 0, 0, 0));
    repeat (6) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);

    // lap freeze at 00.25, release at live 00.40
    run_to(25, 0);
    cycle(0, 1, 0, 0);
    check("lap25", act_word(), exp_word(25, 1, 1, 0));
    run_to(40, 1);
    check("lap_hold", act_word(), exp_word(25, 1, 1, 0));
    cycle(0, 1, 0, 0);
    check("lap40", act_word(), exp_word(40, 1, 0, 0));

    // pause two cycles after a tick; phase survives the pause
    n = 0;
    do begin cycle(0, 0, 0, 1); n++; end while (!m_tick && n < 10);
    v = m_cnt;
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    repeat (20) cycle(0, 0, 0, 1);
    check("frozen", act_word(), exp_word(v, 0, 0, 0));
    cycle(1, 0, 0, 0);
    check("resume0", act_word(), exp_word(v, 1, 0, 0));
    cycle(0, 0, 0, 0);
    check("resume1", act_word(), exp_word(v, 1, 0, 0));
    cycle(0, 0, 0, 0);
    check("resume2", act_word(), exp_word(v + 1, 1, 0, 0));

    // full-scale wrap
    run_to(5999, 0);
    check("at5999", act_word(), exp_word(5999, 1, 0, 0));
    n = 0;
    while (!m_wrap && n < 10) begin cycle(0, 0, 0, 0); n++; end
    check("wrap_edge", act_word(), exp_word(0, 1, 0, 1));
    cycle(0, 0, 0, 0);
    check("wrap_once", act_word(), exp_word(0, 1, 0, 0));

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0, 1);
    end

    // async reset between edges at 12.34
    if (m_mode == 3) cycle(0, 1, 0, 1);
    if (m_mode == 2) cycle(0, 0, 1, 1);
    if (m_mode == 0) cycle(1, 0, 0, 1);
    run_to(1234, 0);
    check("at1234", act_word(), exp_word(1234, 1, 0, 0));
    #2;
    rst_n = 0;
    #1;
    check("async_rst", act_word(), exp_word(0, 0, 0, 0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (8) cycle(0, 0, 0, 1);
    check("post_rst", act_word(), exp_word(0, 0, 0, 0));
    cycle(1, 0, 0, 1);
    repeat (TD) cycle(0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Run/pause/lap timing core of the FPGA stopwatch. It divides the board clock into 10 ms ticks and counts in BCD from 00.00 to 59.99 seconds, wrapping back to 00.00. It presents either the live count or a frozen lap value to the seven-segment display driver downstream. Every digit increment is computed by the team's conditional-sum adder CSA (N=4, b=4'd0, ci=1'b1); the counter registers its outputs, so this block both feeds and consumes that adder.

## Interface
- TICK_DIV, 1_000_000, clock cycles per count tick (100 MHz gives 10 ms). Must be ≥ 2.
- clk  in  1  system clock; all logic rises on its edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  one-cycle pulse, already debounced; toggles run/pause.
- lap  in  1  one-cycle pulse, already debounced; toggles lap freeze.
- clear  in  1  one-cycle pulse; zeroes the count while stopped.
- disp_s_tens  out  3  displayed seconds tens digit (0–5).
- disp_s_ones  out  4  displayed seconds ones digit (0–9).
- disp_cs_tens  out  4  displayed hundredths tens digit (0–9).
- disp_cs_ones  out  4  displayed hundredths ones digit (0–9).
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- wrap  out  1  one-cycle pulse when the count rolls from 59.99 to 00.00.

## Operation
- **State machine states:** IDLE, RUN, PAUSE, LAP.
- **IDLE:** count and prescaler are zero. start_stop → RUN.
- **RUN:**
  - start_stop → PAUSE.
  - lap → LAP, and the lap register captures the live count.
  - clear is ignored.
- **LAP:** the live count keeps advancing; the display shows the lap register.
  - lap → RUN, and the display returns to the live count.
  - start_stop → PAUSE, and the display shows the live count.
  - clear is ignored.
- **PAUSE:** count and prescaler hold.
  - start_stop → RUN.
  - clear → IDLE, and the count and prescaler are zeroed.
  - lap is ignored.
- **Same-cycle priority:**
  - clear beats start_stop in PAUSE.
  - start_stop beats lap in RUN and LAP.
  - Any pulse not listed for the current state is ignored.
- **Prescaler:**
  - Range 0..TICK_DIV-1.
  - Increments only in RUN and LAP.
  - On reaching TICK_DIV-1 it returns to 0 and raises an internal tick.
  - Holds in PAUSE, so the partial tick phase is preserved across pause/resume.
- **Count chain on tick:**
  - cs_ones increments; 9 → 0 carries to cs_tens.
  - cs_tens 9 → 0 carries to s_ones.
  - s_ones 9 → 0 carries to s_tens.
  - s_tens 5 → 0 with all lower digits at 9 means the full count wraps to 00.00, and wrap pulses.
- **Digit arithmetic:**
  - Each digit's next value is the CSA output when the digit is below its limit, otherwise 0.
  - Digits never hold non-BCD values.
  - s_tens uses a 4-bit CSA; its MSB is never set.
- **Lap capture:** the lap register takes the live count present before the capturing edge, i.e. the pre-increment value if a tick coincides with that edge.

## Timing
- **Async reset:** all outputs, count, lap register and prescaler go to 0, and the state goes to IDLE, immediately on rst_n low. No clock edge is needed.
- **Reset release:** first state change on the first rising edge with rst_n high.
- **Pulse-to-status latency:** a pulse sampled at edge k changes state and running/lap_active after edge k. This is one cycle of latency, with registered outputs.
- **First increment:** occurs TICK_DIV edges after the edge that enters RUN from IDLE.
- **Displayed digits:** registered, and update on the same edge as the count or lap capture.
- **wrap:** high for exactly the one cycle following the wrapping edge.
- **Reset mid-run:** the count is lost, and there is no lap or wrap residue afterwards.

## Test plan
All scenarios use TICK_DIV=4.

1. Reset, then start_stop → running=1 after one edge; display reads 00.01 after 4 edges and 00.10 after 40 edges.
2. Run 6000 ticks from 00.00 → display 59.99 at tick 5999; at tick 6000 the display reads 00.00 and wrap is high for exactly one cycle.
3. start_stop two cycles after a tick, wait 20 cycles, start_stop again → count is frozen during PAUSE, and the next increment lands 2 cycles after resume (phase kept).
4. lap at 00.25 → display holds 00.25 and lap_active=1 while live counting continues; second lap at live 00.40 → display 00.40 and lap_active=0.
5. clear in RUN → ignored. In PAUSE at 00.37, clear together with start_stop → IDLE, display 00.00, running=0.
6. Assert rst_n low mid-RUN between clock edges at 12.34 → all outputs read 0 before the next edge; after release, state stays IDLE until start_stop.
